maxpool3x3_window_ctrl: RTL
===========================

Name: maxpool3x3_window_ctrl

Overview:
Sequencer and window generator that feeds the 3x3 FP32 max-pooling pipeline. It accepts one feature-map channel as a raster-order pixel stream and keeps two line buffers plus a 3x3 register window. For every stride-aligned position it presents a complete 3x3 window with a one-cycle valid strobe. It also tracks the fixed pipeline latency, so it can flag each pooled result with its output coordinates and signal frame completion.

Parameters:
DATA_WIDTH, 32, pixel width (FP32 bit pattern, never interpreted)
IMG_W, 32, input frame width in pixels (>=3)
IMG_H, 32, input frame height in pixels (>=3)
STRIDE, 2, pooling stride in both axes (1 or 2)
PIPE_LAT, 4, cycles from win_valid to the pooled result at the datapath output

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse; begins a frame (honoured in IDLE only)
in_data  in  DATA_WIDTH  input pixel
in_valid  in  1  in_data valid
in_ready  out  1  controller accepts a pixel this cycle
win0..win8  out  DATA_WIDTH each  window taps; win0 = (r-2,c-2), win2 = (r-2,c), win6 = (r,c-2), win8 = (r,c), row-major
win_valid  out  1  window taps valid this cycle (drives datapath valid)
out_valid  out  1  pooled result present at the datapath output this cycle
out_row  out  16  output row index of the current result
out_col  out  16  output column index of the current result
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: rst is the asynchronous, active-low reset; clk is the clock. During reset the state is IDLE. All outputs, counters, window registers and the latency delay line are 0. Line-buffer contents are don't-care.
- OUT_W = (IMG_W-3)/STRIDE+1 and OUT_H = (IMG_H-3)/STRIDE+1 (integer division).
- FSM states:
  - IDLE: in_ready=0. start -> RUN; clears row, col, out_row and out_col counters.
  - RUN: in_ready=1. A pixel is accepted when in_valid && in_ready. Acceptance of pixel (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: in_ready=0. Stays until the delay line is empty (PIPE_LAT+1 cycles), then -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start outside IDLE is ignored.
- Accepting pixel p at (r,c):
  - Window columns shift left.
  - The new right column is {lb1[c], lb0[c], p}, where lb1 holds row r-2 and lb0 holds row r-1.
  - Then lb1[c] <= lb0[c] and lb0[c] <= p.
  - col wraps at IMG_W-1 to 0 and increments row.
- Window emission:
  - win_valid=1 in the cycle after accepting (r,c) when r>=2, c>=2, (r-2)%STRIDE==0 and (c-2)%STRIDE==0. Otherwise win_valid=0.
  - Taps hold their value when no pixel is accepted.
  - Windows never straddle a row boundary; the c>=2 gating guarantees this.
- in_valid low in RUN is a stall: no counter, buffer or window change, and win_valid=0.
- Latency tracking:
  - A PIPE_LAT-deep shift register carries win_valid together with (out_row,out_col).
  - out_valid equals win_valid delayed by exactly PIPE_LAT cycles.
  - Coordinates advance column-first: out_col wraps at OUT_W-1 and increments out_row.
- Result counts and ordering: exactly OUT_W*OUT_H results per frame, in raster order, and every out_valid precedes done.
- Simultaneous events:
  - start in DONE is ignored.
  - The last pixel's win_valid and the DRAIN entry occur in the same cycle.
- Reset mid-frame returns to IDLE immediately. Any in-flight out_valid is discarded, and no done pulse is produced.
- Back-to-back frames: start is accepted in the cycle after done. Line buffers need no clearing, because rows 0-1 never emit.

Test Plan:
- IMG_W=5, IMG_H=5, STRIDE=2, PIPE_LAT=4, pixel = r*5+c, in_valid held high.
  - Expect win_valid after pixels 12, 14, 22 and 24, with win0..win8 = {0,1,2,5,6,7,10,11,12} for the first window.
  - Expect 4 out_valid pulses with (out_row,out_col) = (0,0),(0,1),(1,0),(1,1), each 4 cycles after its win_valid.
  - done occurs 5 cycles after the last win_valid.
- Same frame with STRIDE=1: 9 win_valid pulses, last window win8=24 and win0=12, out coordinates (2,2) last.
- STRIDE=2 with in_valid toggled 1,0,1,0: identical window contents and count; win_valid never asserted on a stall cycle.
- start pulsed during RUN and DRAIN: ignored, no counter reset, single done pulse.
- rst asserted after 13 pixels: all outputs 0 in the same cycle, no out_valid or done thereafter. A new start then produces the full 4-result sequence.
- Two frames back-to-back (start the cycle after done), second frame pixel = 100+index: first window win8=112, no leakage of first-frame values into emitted windows.

Source files
------------

// File: rtl/maxpool3x3_window_ctrl.sv
// Raster-order 3x3 window generator for the max-pool datapath: two line buffers feed a tap window,
// and a PIPE_LAT delay line tags each pooled result with its output coordinates and marks frame end.
module maxpool3x3_window_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int STRIDE     = 2,
  parameter int PIPE_LAT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] win0,
  output logic [DATA_WIDTH-1:0] win1,
  output logic [DATA_WIDTH-1:0] win2,
  output logic [DATA_WIDTH-1:0] win3,
  output logic [DATA_WIDTH-1:0] win4,
  output logic [DATA_WIDTH-1:0] win5,
  output logic [DATA_WIDTH-1:0] win6,
  output logic [DATA_WIDTH-1:0] win7,
  output logic [DATA_WIDTH-1:0] win8,
  output logic                  win_valid,
  output logic                  out_valid,
  output logic [15:0]           out_row,
  output logic [15:0]           out_col,
  output logic                  busy,
  output logic                  done
);
  localparam int OUT_W = (IMG_W - 3) / STRIDE + 1;
  localparam int AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int CW    = $clog2(PIPE_LAT + 1) + 1;
  localparam logic [15:0] STRIDE16 = 16'(STRIDE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state;
  logic [15:0]           row;
  logic [15:0]           col;
  logic [15:0]           orow_cnt;
  logic [15:0]           ocol_cnt;
  logic [15:0]           win_row;
  logic [15:0]           win_col;
  logic [CW-1:0]         drain_cnt;
  logic [DATA_WIDTH-1:0] win [9];
  logic [DATA_WIDTH-1:0] lb0 [IMG_W];
  logic [DATA_WIDTH-1:0] lb1 [IMG_W];
  logic                  dl_vld [PIPE_LAT];
  logic [15:0]           dl_row [PIPE_LAT];
  logic [15:0]           dl_col [PIPE_LAT];

  logic          accept;
  logic          last_px;
  logic          emit;
  logic [AW-1:0] cidx;

  assign accept  = (state == S_RUN) && in_valid;
  assign cidx    = col[AW-1:0];
  assign last_px = (row == 16'(IMG_H - 1)) && (col == 16'(IMG_W - 1));
  // Column gating keeps every emitted window inside a single row band.
  assign emit    = (row >= 16'd2) && (col >= 16'd2) &&
                   (((row - 16'd2) % STRIDE16) == 16'd0) &&
                   (((col - 16'd2) % STRIDE16) == 16'd0);

  assign in_ready  = (state == S_RUN);
  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign out_valid = dl_vld[PIPE_LAT-1];
  assign out_row   = dl_row[PIPE_LAT-1];
  assign out_col   = dl_col[PIPE_LAT-1];
  assign win0 = win[0];
  assign win1 = win[1];
  assign win2 = win[2];
  assign win3 = win[3];
  assign win4 = win[4];
  assign win5 = win[5];
  assign win6 = win[6];
  assign win7 = win[7];
  assign win8 = win[8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      row       <= '0;
      col       <= '0;
      orow_cnt  <= '0;
      ocol_cnt  <= '0;
      win_row   <= '0;
      win_col   <= '0;
      drain_cnt <= '0;
      win_valid <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      win_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            row      <= '0;
            col      <= '0;
            orow_cnt <= '0;
            ocol_cnt <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= lb1[cidx];
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= lb0[cidx];
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= in_data;
            if (emit) begin
              win_valid <= 1'b1;
              win_row   <= orow_cnt;
              win_col   <= ocol_cnt;
              if (ocol_cnt == 16'(OUT_W - 1)) begin
                ocol_cnt <= '0;
                orow_cnt <= orow_cnt + 16'd1;
              end else begin
                ocol_cnt <= ocol_cnt + 16'd1;
              end
            end
            if (col == 16'(IMG_W - 1)) begin
              col <= '0;
              row <= row + 16'd1;
            end else begin
              col <= col + 16'd1;
            end
            if (last_px) begin
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        S_DRAIN: begin
          // Hold until the final window has left the delay line.
          if (drain_cnt == CW'(PIPE_LAT)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Line buffers: contents need no reset because rows 0-1 never emit a window.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[cidx] <= lb0[cidx];
      lb0[cidx] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        dl_vld[i] <= 1'b0;
        dl_row[i] <= '0;
        dl_col[i] <= '0;
      end
    end else begin
      dl_vld[0] <= win_valid;
      dl_row[0] <= win_row;
      dl_col[0] <= win_col;
      for (int i = 1; i < PIPE_LAT; i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_row[i] <= dl_row[i-1];
        dl_col[i] <= dl_col[i-1];
      end
    end
  end

endmodule
